// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX->MEM stage: branch kinds, condition codes and NZCV bit positions.
package ex_mem_pkg;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_UNCOND = 2'b01;
  localparam logic [1:0] BR_CBZ    = 2'b10;
  localparam logic [1:0] BR_COND   = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_evaluator.sv
// Combinational evaluation of a B.cond condition field against an NZCV flag set.
module cond_evaluator
  import ex_mem_pkg::*;
(
  input  logic [3:0] condCode,
  input  logic [3:0] nzcv,
  output logic       taken
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (condCode)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_HS: taken = c;
      COND_LO: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !(c && !z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = !(!z && (n == v));
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with architectural NZCV and branch resolution.
// Define EX_MEM_BRANCH_CNT_EN to add the 32-bit takenBranchCount output.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      inValid,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic                      zeroFlag,
  input  logic                      carryFlag,
  input  logic                      negativeFlag,
  input  logic                      overflowFlag,
  input  logic [DATA_WIDTH-1:0]     readDataRegister2,
  input  logic [REG_ADDR_WIDTH-1:0] writeRegister,
  input  logic                      regWrite,
  input  logic                      memRead,
  input  logic                      memWrite,
  input  logic                      memToReg,
  input  logic                      setFlags,
  input  logic [1:0]                branchType,
  input  logic [3:0]                condCode,
  input  logic [DATA_WIDTH-1:0]     branchTarget,
  output logic                      outValid,
  output logic [DATA_WIDTH-1:0]     aluResultMem,
  output logic [DATA_WIDTH-1:0]     writeDataMem,
  output logic [REG_ADDR_WIDTH-1:0] writeRegisterMem,
  output logic                      regWriteMem,
  output logic                      memReadMem,
  output logic                      memWriteMem,
  output logic                      memToRegMem,
  output logic                      pcSrc,
  output logic [DATA_WIDTH-1:0]     branchTargetMem,
  output logic [3:0]                flagsNZCV
`ifdef EX_MEM_BRANCH_CNT_EN
  ,
  output logic [31:0]               takenBranchCount
`endif
);

  logic condTaken_c;
  logic branchTaken_c;

  // B.cond sees the flags as they stood before this edge.
  cond_evaluator uCondEvaluator (
    .condCode (condCode),
    .nzcv     (flagsNZCV),
    .taken    (condTaken_c)
  );

  always_comb begin
    branchTaken_c = 1'b0;
    if (inValid) begin
      case (branchType)
        BR_UNCOND: branchTaken_c = 1'b1;
        BR_CBZ:    branchTaken_c = zeroFlag;
        BR_COND:   branchTaken_c = condTaken_c;
        BR_NONE:   branchTaken_c = 1'b0;
        default:   branchTaken_c = 1'b0;
      endcase
    end
  end

  // Pipeline register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid         <= 1'b0;
      aluResultMem     <= '0;
      writeDataMem     <= '0;
      writeRegisterMem <= '0;
      regWriteMem      <= 1'b0;
      memReadMem       <= 1'b0;
      memWriteMem      <= 1'b0;
      memToRegMem      <= 1'b0;
      pcSrc            <= 1'b0;
      branchTargetMem  <= '0;
      flagsNZCV        <= 4'b0000;
    end else if (flush) begin
      outValid    <= 1'b0;
      regWriteMem <= 1'b0;
      memReadMem  <= 1'b0;
      memWriteMem <= 1'b0;
      memToRegMem <= 1'b0;
      pcSrc       <= 1'b0;
    end else if (!stall) begin
      outValid         <= inValid;
      aluResultMem     <= ALUResult;
      writeDataMem     <= readDataRegister2;
      writeRegisterMem <= writeRegister;
      regWriteMem      <= regWrite && inValid;
      memReadMem       <= memRead && inValid;
      memWriteMem      <= memWrite && inValid;
      memToRegMem      <= memToReg && inValid;
      pcSrc            <= branchTaken_c;
      branchTargetMem  <= branchTarget;
      if (inValid && setFlags) begin
        flagsNZCV <= {negativeFlag, zeroFlag, carryFlag, overflowFlag};
      end
    end
  end

`ifdef EX_MEM_BRANCH_CNT_EN
  localparam int unsigned CNT_WIDTH = 32;

  // Counts taken branches that actually enter MEM; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      takenBranchCount <= '0;
    end else if (!flush && !stall && branchTaken_c) begin
      takenBranchCount <= takenBranchCount + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed vector table plus randomized run against a reference model.
module tb_ex_mem_stage;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset, stall, flush, inValid;
  logic [DW-1:0] ALUResult, readDataRegister2, branchTarget;
  logic          zeroFlag, carryFlag, negativeFlag, overflowFlag;
  logic [AW-1:0] writeRegister;
  logic          regWrite, memRead, memWrite, memToReg, setFlags;
  logic [1:0]    branchType;
  logic [3:0]    condCode;
  logic          outValid, regWriteMem, memReadMem, memWriteMem, memToRegMem, pcSrc;
  logic [DW-1:0] aluResultMem, writeDataMem, branchTargetMem;
  logic [AW-1:0] writeRegisterMem;
  logic [3:0]    flagsNZCV;
`ifdef EX_MEM_BRANCH_CNT_EN
  logic [31:0]   takenBranchCount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .inValid(inValid),
    .ALUResult(ALUResult), .zeroFlag(zeroFlag), .carryFlag(carryFlag),
    .negativeFlag(negativeFlag), .overflowFlag(overflowFlag),
    .readDataRegister2(readDataRegister2), .writeRegister(writeRegister),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .setFlags(setFlags), .branchType(branchType), .condCode(condCode),
    .branchTarget(branchTarget), .outValid(outValid), .aluResultMem(aluResultMem),
    .writeDataMem(writeDataMem), .writeRegisterMem(writeRegisterMem),
    .regWriteMem(regWriteMem), .memReadMem(memReadMem), .memWriteMem(memWriteMem),
    .memToRegMem(memToRegMem), .pcSrc(pcSrc), .branchTargetMem(branchTargetMem),
    .flagsNZCV(flagsNZCV)
`ifdef EX_MEM_BRANCH_CNT_EN
    , .takenBranchCount(takenBranchCount)
`endif
  );

  typedef struct packed {
    logic        rst, stl, fls, vld, sf, rw, mw;
    logic [3:0]  flags;   // {N,Z,C,V}
    logic [1:0]  br;
    logic [3:0]  cc;
    logic [4:0]  wreg;
    logic [63:0] alu;
    logic        eValid, ePc, eRegW, eMemW;
    logic [3:0]  eNzcv;
    logic [4:0]  eWreg;
    logic [63:0] eAlu;
  } vec_t;

  vec_t tab[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; flush = v.fls; inValid = v.vld;
    setFlags = v.sf; regWrite = v.rw; memWrite = v.mw;
    memRead = v.mw; memToReg = v.rw;
    {negativeFlag, zeroFlag, carryFlag, overflowFlag} = v.flags;
    branchType = v.br; condCode = v.cc; writeRegister = v.wreg;
    ALUResult = v.alu; readDataRegister2 = ~v.alu; branchTarget = v.alu + 64'd4;
  endtask

  // Reference: ARM-style evaluation -- base test from cc[3:1], inverted by cc[0] except for 111x.
  function automatic logic condHolds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (cc[0] && cc[3:1] != 3'd7) r = ~r;
    return r;
  endfunction

  // Model state
  logic          mValid, mRegW, mMemR, mMemW, mM2R, mPc;
  logic [DW-1:0] mAlu, mWd, mBt;
  logic [AW-1:0] mWreg;
  logic [3:0]    mNzcv;
  logic [31:0]   mCnt;

  task automatic modelStep();
    logic tk;
    if (reset) begin
      {mValid, mRegW, mMemR, mMemW, mM2R, mPc} = '0;
      mAlu = '0; mWd = '0; mBt = '0; mWreg = '0; mNzcv = '0; mCnt = '0;
    end else if (flush) begin
      {mValid, mRegW, mMemR, mMemW, mM2R, mPc} = '0;
    end else if (!stall) begin
      tk = 1'b0;
      if (inValid) begin
        if (branchType == 2'd1) tk = 1'b1;
        else if (branchType == 2'd2) tk = zeroFlag;
        else if (branchType == 2'd3) tk = condHolds(condCode, mNzcv);
      end
      mValid = inValid;
      mRegW = regWrite & inValid; mMemR = memRead & inValid;
      mMemW = memWrite & inValid; mM2R = memToReg & inValid;
      mPc = tk;
      mAlu = ALUResult; mWd = readDataRegister2; mBt = branchTarget; mWreg = writeRegister;
      if (inValid && setFlags) mNzcv = {negativeFlag, zeroFlag, carryFlag, overflowFlag};
      if (tk) mCnt = mCnt + 32'd1;
    end
  endtask

  task automatic checkModel();
    check("rnd.outValid", 64'(outValid), 64'(mValid));
    check("rnd.regWriteMem", 64'(regWriteMem), 64'(mRegW));
    check("rnd.memReadMem", 64'(memReadMem), 64'(mMemR));
    check("rnd.memWriteMem", 64'(memWriteMem), 64'(mMemW));
    check("rnd.memToRegMem", 64'(memToRegMem), 64'(mM2R));
    check("rnd.pcSrc", 64'(pcSrc), 64'(mPc));
    check("rnd.aluResultMem", aluResultMem, mAlu);
    check("rnd.writeDataMem", writeDataMem, mWd);
    check("rnd.branchTargetMem", branchTargetMem, mBt);
    check("rnd.writeRegisterMem", 64'(writeRegisterMem), 64'(mWreg));
    check("rnd.flagsNZCV", 64'(flagsNZCV), 64'(mNzcv));
`ifdef EX_MEM_BRANCH_CNT_EN
    check("rnd.takenBranchCount", 64'(takenBranchCount), 64'(mCnt));
`endif
  endtask

  initial begin
    vec_t v;
    vec_t rec;

    // ---- directed table ----
    v = '1; v.eValid = 0; v.ePc = 0; v.eRegW = 0; v.eMemW = 0;
    v.eNzcv = 0; v.eWreg = 0; v.eAlu = 0;
    tab[0] = v;                                               // reset with all inputs high

    v = '0; v.vld = 1; v.alu = 64'h2A; v.wreg = 9; v.rw = 1;
    v.eValid = 1; v.eRegW = 1; v.eAlu = 64'h2A; v.eWreg = 9;
    tab[1] = v;

    v = '0; v.vld = 1; v.sf = 1; v.flags = 4'b0110; v.wreg = 1; v.rw = 1;
    v.eValid = 1; v.eRegW = 1; v.eWreg = 1; v.eNzcv = 4'b0110;
    tab[2] = v;                                               // SUBS Z=1 C=1

    v = '0; v.vld = 1; v.br = 2'b11; v.cc = 4'b0000; v.alu = 64'h100;
    v.eValid = 1; v.ePc = 1; v.eAlu = 64'h100; v.eNzcv = 4'b0110;
    tab[3] = v;                                               // B.EQ taken

    v = '0; v.vld = 1; v.br = 2'b11; v.cc = 4'b0001; v.alu = 64'h104;
    v.eValid = 1; v.ePc = 0; v.eAlu = 64'h104; v.eNzcv = 4'b0110;
    tab[4] = v;                                               // B.NE not taken

    for (int i = 5; i < 8; i++) begin
      v = '0; v.stl = 1; v.vld = 1; v.sf = 1; v.flags = 4'b1001; v.br = 2'b01;
      v.mw = 1; v.wreg = 3; v.alu = 64'h55 + 64'(i);
      v.eValid = 1; v.ePc = 0; v.eAlu = 64'h104; v.eNzcv = 4'b0110;
      tab[i] = v;                                             // stalled, inputs changing
    end

    v = '0; v.vld = 1; v.sf = 1; v.flags = 4'b1001; v.br = 2'b01; v.mw = 1;
    v.wreg = 3; v.alu = 64'h55;
    v.eValid = 1; v.ePc = 1; v.eMemW = 1; v.eWreg = 3; v.eAlu = 64'h55; v.eNzcv = 4'b1001;
    tab[8] = v;                                               // stall released

    v = '0; v.fls = 1; v.vld = 1; v.mw = 1; v.br = 2'b01; v.sf = 1; v.flags = 4'b0110;
    v.alu = 64'h99; v.wreg = 7;
    v.eValid = 0; v.ePc = 0; v.eMemW = 0; v.eWreg = 3; v.eAlu = 64'h55; v.eNzcv = 4'b1001;
    tab[9] = v;                                               // flush holds data, kills control

    v = '0; v.vld = 0; v.mw = 1; v.rw = 1; v.br = 2'b01; v.sf = 1; v.alu = 64'h77; v.wreg = 4;
    v.eWreg = 4; v.eAlu = 64'h77; v.eNzcv = 4'b1001;
    tab[10] = v;                                              // invalid input gated

    v = '0; v.vld = 1; v.sf = 1; v.flags = 4'b0100; v.br = 2'b11; v.cc = 4'b0000; v.alu = 64'h200;
    v.eValid = 1; v.ePc = 0; v.eAlu = 64'h200; v.eNzcv = 4'b0100;
    tab[11] = v;                                              // own flags not visible

    v = '0; v.vld = 1; v.br = 2'b11; v.cc = 4'b0000; v.alu = 64'h204;
    v.eValid = 1; v.ePc = 1; v.eAlu = 64'h204; v.eNzcv = 4'b0100;
    tab[12] = v;                                              // back-to-back sees them

    v = '0; v.vld = 1; v.br = 2'b10; v.flags = 4'b0100;
    v.eValid = 1; v.ePc = 1; v.eNzcv = 4'b0100;
    tab[13] = v;                                              // CBZ zero

    v = '0; v.vld = 1; v.br = 2'b10; v.alu = 64'h5;
    v.eValid = 1; v.ePc = 0; v.eAlu = 64'h5; v.eNzcv = 4'b0100;
    tab[14] = v;                                              // CBZ nonzero

    v = '0; v.vld = 1; v.br = 2'b11; v.cc = 4'b1110;
    v.eValid = 1; v.ePc = 1; v.eNzcv = 4'b0100;
    tab[15] = v;                                              // AL

    v = '0; v.vld = 1; v.br = 2'b11; v.cc = 4'b1100;
    v.eValid = 1; v.ePc = 0; v.eNzcv = 4'b0100;
    tab[16] = v;                                              // GT with Z=1

    v = '0; v.rst = 1; v.stl = 1; v.fls = 1; v.vld = 1; v.mw = 1; v.alu = 64'h33; v.wreg = 2;
    tab[17] = v;                                              // reset wins over stall+flush

    v = '0; v.vld = 1; v.br = 2'b11; v.cc = 4'b1111;
    v.eValid = 1; v.ePc = 1;
    tab[18] = v;                                              // NV also taken

    for (int i = 0; i < 19; i++) begin
      rec = tab[i];
      drive(rec);
      @(posedge clk); #1;
      check($sformatf("vec%0d.outValid", i), 64'(outValid), 64'(rec.eValid));
      check($sformatf("vec%0d.pcSrc", i), 64'(pcSrc), 64'(rec.ePc));
      check($sformatf("vec%0d.regWriteMem", i), 64'(regWriteMem), 64'(rec.eRegW));
      check($sformatf("vec%0d.memWriteMem", i), 64'(memWriteMem), 64'(rec.eMemW));
      check($sformatf("vec%0d.flagsNZCV", i), 64'(flagsNZCV), 64'(rec.eNzcv));
      check($sformatf("vec%0d.writeRegisterMem", i), 64'(writeRegisterMem), 64'(rec.eWreg));
      check($sformatf("vec%0d.aluResultMem", i), aluResultMem, rec.eAlu);
    end

`ifdef EX_MEM_BRANCH_CNT_EN
    // 5 taken (one flushed) + 3 not taken -> count of 4
    v = '0; v.rst = 1; drive(v); @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      v = '0; v.vld = 1;
      if (i < 5) begin v.br = 2'b01; v.fls = (i == 2); end
      else if (i == 5) v.br = 2'b00;
      else if (i == 6) begin v.br = 2'b10; v.flags = 4'b0000; end
      else begin v.br = 2'b11; v.cc = 4'b0000; end
      drive(v); @(posedge clk); #1;
    end
    check("cnt.takenBranchCount", 64'(takenBranchCount), 64'd4);
`endif

    // ---- randomized run against the model ----
    v = '0; v.rst = 1; drive(v);
    modelStep();
    @(posedge clk); #1;
    checkModel();
    for (int i = 0; i < 600; i++) begin
      reset             = ($urandom_range(0, 49) == 0);
      stall             = ($urandom_range(0, 4) == 0);
      flush             = ($urandom_range(0, 6) == 0);
      inValid           = ($urandom_range(0, 3) != 0);
      ALUResult         = {$urandom, $urandom};
      readDataRegister2 = {$urandom, $urandom};
      branchTarget      = {$urandom, $urandom};
      {negativeFlag, zeroFlag, carryFlag, overflowFlag} = 4'($urandom);
      writeRegister     = 5'($urandom);
      {regWrite, memRead, memWrite, memToReg} = 4'($urandom);
      setFlags          = 1'($urandom);
      branchType        = 2'($urandom);
      condCode          = 4'($urandom);
      modelStep();
      @(posedge clk); #1;
      checkModel();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX→MEM pipeline stage directly downstream of the ALU.
- Registers the ALU result, store data, destination register and MEM/WB control signals.
- Keeps the architectural NZCV flag register, loaded from the ALU flag outputs.
- Resolves the branch decision (B, CBZ, B.cond) and registers pcSrc and branch target for the fetch stage.

Parameters:
- DATA_WIDTH, 64, datapath width of result, store data and branch target.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all registered state; no update this cycle.
- flush  input  1  insert a bubble; kill the incoming instruction.
- inValid  input  1  EX holds a real instruction.
- ALUResult  input  DATA_WIDTH  ALU result.
- zeroFlag / carryFlag / negativeFlag / overflowFlag  input  1 each  ALU flags.
- readDataRegister2  input  DATA_WIDTH  store data.
- writeRegister  input  REG_ADDR_WIDTH  destination register.
- regWrite / memRead / memWrite / memToReg  input  1 each  downstream control.
- setFlags  input  1  instruction writes NZCV.
- branchType  input  2  00 none, 01 B, 10 CBZ, 11 B.cond.
- condCode  input  4  B.cond condition field.
- branchTarget  input  DATA_WIDTH  computed PC target.
- outValid  output  1  MEM holds a real instruction.
- aluResultMem  output  DATA_WIDTH  registered ALU result.
- writeDataMem  output  DATA_WIDTH  registered store data.
- writeRegisterMem  output  REG_ADDR_WIDTH  registered destination register.
- regWriteMem / memReadMem / memWriteMem / memToRegMem  output  1 each  registered control.
- pcSrc  output  1  registered branch-taken.
- branchTargetMem  output  DATA_WIDTH  registered target.
- flagsNZCV  output  4  architectural flags {N,Z,C,V}.

Behaviour:
- Reset (synchronous, active-high): every output is 0, including NZCV, outValid and pcSrc.
- Latency: 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
- Priority: reset > flush > stall > normal load.
- Flush:
  - outValid, regWriteMem, memReadMem, memWriteMem, memToRegMem and pcSrc go to 0.
  - Data fields are don't-care; the implementation holds them.
  - NZCV is not updated.
- Stall without flush: all registers, including NZCV, hold their values. The flags are not updated even if setFlags=1.
- Normal load:
  - All fields load from the inputs.
  - outValid = inValid.
  - Control outputs are ANDed with inValid, so an invalid input never writes memory or registers.
- NZCV update: when loading with inValid & setFlags, NZCV ← {negativeFlag, zeroFlag, carryFlag, overflowFlag}.
- Branch decision (combinational before the register; only when loading with inValid, otherwise 0):
  - 01: taken.
  - 10: taken iff zeroFlag. The ALU is passing the register through, so zeroFlag means the register is zero.
  - 11: taken iff condCode holds against NZCV as it was before this edge. Flags set by the same instruction are not visible to it.
  - 00: not taken.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !(C&!Z).
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE !(GT).
  - 1110 and 1111: always taken.
- Back-to-back: instruction A sets flags, then B.cond follows the next cycle with no stall. B sees A's flags.
- Reset asserted mid-stall or mid-flush: reset wins on that edge.

Optional Feature:
- Macro: EX_MEM_BRANCH_CNT_EN.
- Defined: adds output takenBranchCount, 32 bits.
  - Increments on every edge where a taken branch is loaded, i.e. pcSrc becomes 1 for a valid instruction.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset; held during stall and flush.
- Undefined: the port and the counter logic are absent.

Decomposition:
- Shared package ex_mem_pkg holds:
  - branchType constants BR_NONE/BR_UNCOND/BR_CBZ/BR_COND;
  - the 16 condition-code constants;
  - NZCV bit-index constants.
- Sub-module cond_evaluator: combinational; inputs condCode and NZCV, output taken. The future flag-forwarding logic will reuse it.

Test Plan:
- Reset with all inputs at 1 → one edge later every output is 0 and NZCV=0000.
- Load with inValid=1, ALUResult=0x0000_0000_0000_002A, writeRegister=9, regWrite=1 → next cycle aluResultMem=0x2A, writeRegisterMem=9, regWriteMem=1, outValid=1.
- SUBS with setFlags=1, Z=1, C=1 → NZCV=0110; B.cond EQ next cycle → pcSrc=1; a following B.cond NE → pcSrc=0.
- stall=1 for 3 cycles while the inputs change, including setFlags=1 → outputs and NZCV unchanged; release stall → loads the current inputs.
- flush=1 with memWrite=1, branchType=01 → memWriteMem=0, pcSrc=0, outValid=0, NZCV unchanged.
- With EX_MEM_BRANCH_CNT_EN: 5 taken and 3 not-taken branches, with one taken branch flushed → takenBranchCount=4.
